// File: rtl/matmul_pkg.sv
// Shared types and helpers for the matrix-tile engine: FSM state encoding,
// error-flag bit positions and counter sizing.
package matmul_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_COMPUTE,
        S_OUTPUT,
        S_DONE
    } state_t;

    localparam int ERR_CFG   = 0;
    localparam int ERR_TLAST = 1;

    // Wide enough to hold the maximum itself, not just max-1.
    function automatic int cnt_w(input int max);
        return $clog2(max) + 1;
    endfunction

endpackage

// File: rtl/matmul_tile_engine_mac_unit.sv
// Combinational signed multiply-accumulate: full-width product, sign-extended
// or truncated to ACC_W, added modulo 2^ACC_W to the (optionally cleared) accumulator.
module mac_unit #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 64
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [ACC_W-1:0]  acc_i,
    input  logic              clear_i,
    output logic [ACC_W-1:0]  sum_o
);

    localparam int PROD_W = 2 * DATA_W;

    logic [PROD_W-1:0] a_ext;
    logic [PROD_W-1:0] b_ext;
    logic [PROD_W-1:0] prod;
    logic [ACC_W-1:0]  prod_acc;

    // Low PROD_W bits of the product of sign-extended operands equal the signed product.
    assign a_ext = {{DATA_W{a_i[DATA_W-1]}}, a_i};
    assign b_ext = {{DATA_W{b_i[DATA_W-1]}}, b_i};
    assign prod  = a_ext * b_ext;

    generate
        if (ACC_W > PROD_W) begin : g_sext
            assign prod_acc = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
        end else if (ACC_W == PROD_W) begin : g_same
            assign prod_acc = prod;
        end else begin : g_trunc
            assign prod_acc = prod[ACC_W-1:0];
        end
    endgenerate

    assign sum_o = (clear_i ? '0 : acc_i) + prod_acc;

endmodule

// File: rtl/matmul_tile_engine.sv
// AXI-Stream matrix-tile engine: loads A (MxK) then B (KxN), runs one MAC per
// cycle into an MxN accumulator array, then streams C row-major.
module matmul_tile_engine
    import matmul_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 64,
    parameter int M_MAX  = 4,
    parameter int N_MAX  = 4,
    parameter int K_MAX  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_axis_a_tdata,
    input  logic              s_axis_a_tvalid,
    output logic              s_axis_a_tready,
    input  logic              s_axis_a_tlast,
    input  logic [DATA_W-1:0] s_axis_b_tdata,
    input  logic              s_axis_b_tvalid,
    output logic              s_axis_b_tready,
    input  logic              s_axis_b_tlast,
    output logic [ACC_W-1:0]  m_axis_c_tdata,
    output logic              m_axis_c_tvalid,
    input  logic              m_axis_c_tready,
    output logic              m_axis_c_tlast,
    input  logic [7:0]        cfg_m,
    input  logic [7:0]        cfg_n,
    input  logic [15:0]       cfg_k,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err
);

    localparam int M_W  = cnt_w(M_MAX);
    localparam int N_W  = cnt_w(N_MAX);
    localparam int K_W  = cnt_w(K_MAX);
    localparam int MI_W = (M_MAX > 1) ? $clog2(M_MAX) : 1;
    localparam int NI_W = (N_MAX > 1) ? $clog2(N_MAX) : 1;
    localparam int KI_W = (K_MAX > 1) ? $clog2(K_MAX) : 1;

    state_t         state_q, state_d;
    logic [M_W-1:0] m_q, m_d, ci_q, ci_d;
    logic [N_W-1:0] n_q, n_d, cj_q, cj_d;
    logic [K_W-1:0] kk_q, kk_d, ck_q, ck_d;
    logic [1:0]     err_q, err_d;
    logic           cfg_done_q, cfg_done_d;

    logic [DATA_W-1:0] a_mem   [M_MAX][K_MAX];
    logic [DATA_W-1:0] b_mem   [K_MAX][N_MAX];
    logic [ACC_W-1:0]  acc_mem [M_MAX][N_MAX];

    logic              a_we, b_we, acc_we;
    logic              last_i, last_j, last_k, cfg_bad;
    logic [ACC_W-1:0]  mac_sum;
    logic [MI_W-1:0]   ri;
    logic [NI_W-1:0]   rj;
    logic [KI_W-1:0]   rk;

    assign ri = ci_q[MI_W-1:0];
    assign rj = cj_q[NI_W-1:0];
    assign rk = ck_q[KI_W-1:0];

    assign last_i = (ci_q + M_W'(1)) == m_q;
    assign last_j = (cj_q + N_W'(1)) == n_q;
    assign last_k = (ck_q + K_W'(1)) == kk_q;

    assign cfg_bad = (cfg_m == '0) || (cfg_n == '0) || (cfg_k == '0)
                   || (int'(cfg_m) > M_MAX) || (int'(cfg_n) > N_MAX)
                   || (int'(cfg_k) > K_MAX);

    mac_unit #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .a_i     (a_mem[ri][rk]),
        .b_i     (b_mem[rk][rj]),
        .acc_i   (acc_mem[ri][rj]),
        .clear_i (ck_q == '0),
        .sum_o   (mac_sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            m_q        <= '0;
            n_q        <= '0;
            kk_q       <= '0;
            ci_q       <= '0;
            cj_q       <= '0;
            ck_q       <= '0;
            err_q      <= '0;
            cfg_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            m_q        <= m_d;
            n_q        <= n_d;
            kk_q       <= kk_d;
            ci_q       <= ci_d;
            cj_q       <= cj_d;
            ck_q       <= ck_d;
            err_q      <= err_d;
            cfg_done_q <= cfg_done_d;
        end
    end

    // Buffers carry no reset; their contents are rewritten before every use.
    always_ff @(posedge clk) begin
        if (a_we)   a_mem[ri][rk]   <= s_axis_a_tdata;
        if (b_we)   b_mem[rk][rj]   <= s_axis_b_tdata;
        if (acc_we) acc_mem[ri][rj] <= mac_sum;
    end

    // Handshakes: a beat transfers on a rising edge where tvalid and tready are
    // both high; C tdata/tlast stay fixed until that transfer happens.
    always_comb begin
        state_d         = state_q;
        m_d             = m_q;
        n_d             = n_q;
        kk_d            = kk_q;
        ci_d            = ci_q;
        cj_d            = cj_q;
        ck_d            = ck_q;
        err_d           = err_q;
        cfg_done_d      = 1'b0;
        a_we            = 1'b0;
        b_we            = 1'b0;
        acc_we          = 1'b0;
        s_axis_a_tready = 1'b0;
        s_axis_b_tready = 1'b0;
        m_axis_c_tvalid = 1'b0;
        m_axis_c_tlast  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    m_d   = cfg_m[M_W-1:0];
                    n_d   = cfg_n[N_W-1:0];
                    kk_d  = cfg_k[K_W-1:0];
                    ci_d  = '0;
                    cj_d  = '0;
                    ck_d  = '0;
                    err_d = 2'b00;
                    if (cfg_bad) begin
                        err_d[ERR_CFG] = 1'b1;
                        cfg_done_d     = 1'b1;
                    end else begin
                        state_d = S_LOAD_A;
                    end
                end
            end
            S_LOAD_A: begin
                s_axis_a_tready = 1'b1;
                if (s_axis_a_tvalid) begin
                    a_we = 1'b1;
                    if (s_axis_a_tlast != (last_i && last_k)) err_d[ERR_TLAST] = 1'b1;
                    if (last_k) begin
                        ck_d = '0;
                        if (last_i) begin
                            ci_d    = '0;
                            state_d = S_LOAD_B;
                        end else begin
                            ci_d = ci_q + M_W'(1);
                        end
                    end else begin
                        ck_d = ck_q + K_W'(1);
                    end
                end
            end
            S_LOAD_B: begin
                s_axis_b_tready = 1'b1;
                if (s_axis_b_tvalid) begin
                    b_we = 1'b1;
                    if (s_axis_b_tlast != (last_k && last_j)) err_d[ERR_TLAST] = 1'b1;
                    if (last_j) begin
                        cj_d = '0;
                        if (last_k) begin
                            ck_d    = '0;
                            state_d = S_COMPUTE;
                        end else begin
                            ck_d = ck_q + K_W'(1);
                        end
                    end else begin
                        cj_d = cj_q + N_W'(1);
                    end
                end
            end
            S_COMPUTE: begin
                acc_we = 1'b1;
                if (last_k) begin
                    ck_d = '0;
                    if (last_j) begin
                        cj_d = '0;
                        if (last_i) begin
                            ci_d    = '0;
                            state_d = S_OUTPUT;
                        end else begin
                            ci_d = ci_q + M_W'(1);
                        end
                    end else begin
                        cj_d = cj_q + N_W'(1);
                    end
                end else begin
                    ck_d = ck_q + K_W'(1);
                end
            end
            S_OUTPUT: begin
                m_axis_c_tvalid = 1'b1;
                m_axis_c_tlast  = last_i && last_j;
                if (m_axis_c_tready) begin
                    if (last_j) begin
                        cj_d = '0;
                        if (last_i) begin
                            ci_d    = '0;
                            state_d = S_DONE;
                        end else begin
                            ci_d = ci_q + M_W'(1);
                        end
                    end else begin
                        cj_d = cj_q + N_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign m_axis_c_tdata = (state_q == S_OUTPUT) ? acc_mem[ri][rj] : '0;
    assign busy           = (state_q != S_IDLE);
    assign done           = (state_q == S_DONE) || cfg_done_q;
    assign err            = err_q;

endmodule

// File: tb/tb_matmul_tile_engine.sv
// Directed bench for matmul_tile_engine: hand-computed tiles, backpressure,
// tlast errors, invalid configs, maximum tile and mid-load reset.
module tb_matmul_tile_engine;

    localparam int DATA_W = 32;
    localparam int ACC_W  = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] s_axis_a_tdata, s_axis_b_tdata;
    logic              s_axis_a_tvalid, s_axis_a_tready, s_axis_a_tlast;
    logic              s_axis_b_tvalid, s_axis_b_tready, s_axis_b_tlast;
    logic [ACC_W-1:0]  m_axis_c_tdata;
    logic              m_axis_c_tvalid, m_axis_c_tready, m_axis_c_tlast;
    logic [7:0]        cfg_m, cfg_n;
    logic [15:0]       cfg_k;
    logic              start, busy, done;
    logic [1:0]        err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [DATA_W-1:0] a_vec[$];
    logic [DATA_W-1:0] b_vec[$];
    logic [ACC_W-1:0]  exp_q[$];
    logic [ACC_W-1:0]  got_q[$];
    logic              got_last_q[$];

    int a_last_idx;
    bit b_omit_last, bp_mode, start_in_output;
    int a_hs, b_hs, c_hs, first_c_cyc, last_b_cyc, done_pulses;
    bit overlap_seen = 1'b0;

    matmul_tile_engine #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .M_MAX  (4),
        .N_MAX  (4),
        .K_MAX  (64)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .s_axis_a_tdata  (s_axis_a_tdata),
        .s_axis_a_tvalid (s_axis_a_tvalid),
        .s_axis_a_tready (s_axis_a_tready),
        .s_axis_a_tlast  (s_axis_a_tlast),
        .s_axis_b_tdata  (s_axis_b_tdata),
        .s_axis_b_tvalid (s_axis_b_tvalid),
        .s_axis_b_tready (s_axis_b_tready),
        .s_axis_b_tlast  (s_axis_b_tlast),
        .m_axis_c_tdata  (m_axis_c_tdata),
        .m_axis_c_tvalid (m_axis_c_tvalid),
        .m_axis_c_tready (m_axis_c_tready),
        .m_axis_c_tlast  (m_axis_c_tlast),
        .cfg_m           (cfg_m),
        .cfg_n           (cfg_n),
        .cfg_k           (cfg_k),
        .start           (start),
        .busy            (busy),
        .done            (done),
        .err             (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (s_axis_a_tready && s_axis_b_tready) overlap_seen <= 1'b1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drive_a();
        int idx = 0;
        int guard = 0;
        a_hs = 0;
        while (idx < a_vec.size() && guard < 4000) begin
            s_axis_a_tdata  = a_vec[idx];
            s_axis_a_tvalid = 1'b1;
            s_axis_a_tlast  = (idx == a_last_idx);
            if (s_axis_a_tready) begin
                idx++;
                a_hs++;
            end
            @(posedge clk); #1;
            guard++;
        end
        s_axis_a_tvalid = 1'b0;
        s_axis_a_tlast  = 1'b0;
    endtask

    task automatic drive_b();
        int idx = 0;
        int guard = 0;
        bit hs_now;
        b_hs = 0;
        last_b_cyc = -1;
        while (idx < b_vec.size() && guard < 4000) begin
            s_axis_b_tdata  = b_vec[idx];
            s_axis_b_tvalid = 1'b1;
            s_axis_b_tlast  = b_omit_last ? 1'b0 : (idx == b_vec.size() - 1);
            hs_now = s_axis_b_tready;
            if (hs_now) begin
                idx++;
                b_hs++;
            end
            @(posedge clk); #1;
            guard++;
            if (hs_now && idx == b_vec.size()) last_b_cyc = cyc;
        end
        s_axis_b_tvalid = 1'b0;
        s_axis_b_tlast  = 1'b0;
    endtask

    task automatic collect_c(input int exp_n);
        int guard = 0;
        int post = 0;
        bit stalled = 1'b0;
        bit pulsed = 1'b0;
        logic [ACC_W-1:0] hold_d;
        logic hold_l;
        c_hs = 0;
        first_c_cyc = -1;
        done_pulses = 0;
        got_q.delete();
        got_last_q.delete();
        m_axis_c_tready = 1'b1;
        while (guard < 4000 && post < 4) begin
            start = 1'b0;
            if (done) done_pulses++;
            if (c_hs == exp_n) post++;
            if (m_axis_c_tvalid) begin
                if (first_c_cyc < 0) first_c_cyc = cyc;
                if (bp_mode && !stalled) begin
                    m_axis_c_tready = 1'b0;
                    hold_d  = m_axis_c_tdata;
                    hold_l  = m_axis_c_tlast;
                    stalled = 1'b1;
                end else begin
                    if (stalled) begin
                        chk("c_hold_data", m_axis_c_tdata, hold_d);
                        chk("c_hold_last", 64'(m_axis_c_tlast), 64'(hold_l));
                    end
                    m_axis_c_tready = 1'b1;
                    stalled = 1'b0;
                    got_q.push_back(m_axis_c_tdata);
                    got_last_q.push_back(m_axis_c_tlast);
                    c_hs++;
                    if (start_in_output && !pulsed) begin
                        start  = 1'b1;
                        pulsed = 1'b1;
                    end
                end
            end
            @(posedge clk); #1;
            guard++;
        end
        start = 1'b0;
        m_axis_c_tready = 1'b0;
    endtask

    task automatic run_op(input int m, input int n, input int k, input logic [1:0] exp_err);
        int start_cyc;
        int exp_n;
        exp_n = exp_q.size();
        cfg_m = 8'(m);
        cfg_n = 8'(n);
        cfg_k = 16'(k);
        start = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        fork
            drive_a();
            drive_b();
            collect_c(exp_n);
        join
        chk("a_beats", 64'(a_hs), 64'(m * k));
        chk("b_beats", 64'(b_hs), 64'(n * k));
        chk("c_beats", 64'(c_hs), 64'(exp_n));
        for (int i = 0; i < exp_n && i < got_q.size(); i++) begin
            chk($sformatf("c_data[%0d]", i), got_q[i], exp_q[i]);
            chk($sformatf("c_last[%0d]", i), 64'(got_last_q[i]), 64'(i == exp_n - 1));
        end
        chk("latency", 64'(first_c_cyc - start_cyc), 64'(1 + m * k + n * k + m * n * k));
        chk("compute_len", 64'(first_c_cyc - last_b_cyc), 64'(m * n * k));
        chk("done_pulses", 64'(done_pulses), 64'd1);
        chk("err", 64'(err), 64'(exp_err));
        chk("busy_after", 64'(busy), 64'd0);
        chk("ab_overlap", 64'(overlap_seen), 64'd0);
    endtask

    task automatic run_bad(input int m, input int n, input int k);
        cfg_m = 8'(m);
        cfg_n = 8'(n);
        cfg_k = 16'(k);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("bad_done", 64'(done), 64'd1);
        chk("bad_err", 64'(err), 64'd1);
        chk("bad_busy", 64'(busy), 64'd0);
        chk("bad_tready", 64'({s_axis_a_tready, s_axis_b_tready}), 64'd0);
        @(posedge clk); #1;
        chk("bad_done_drop", 64'(done), 64'd0);
        chk("bad_err_hold", 64'(err), 64'd1);
        chk("bad_busy2", 64'(busy), 64'd0);
        chk("bad_tready2", 64'({s_axis_a_tready, s_axis_b_tready}), 64'd0);
    endtask

    task automatic set_basic();
        a_vec = '{32'd1, 32'd2, 32'd3, 32'd4};
        b_vec = '{32'd5, 32'd6, 32'd7, 32'd8};
        exp_q = '{64'd19, 64'd22, 64'd43, 64'd50};
        a_last_idx = 3;
        b_omit_last = 1'b0;
        bp_mode = 1'b0;
        start_in_output = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_err"}, 64'(err), 64'd0);
        chk({tag, "_a_tready"}, 64'(s_axis_a_tready), 64'd0);
        chk({tag, "_b_tready"}, 64'(s_axis_b_tready), 64'd0);
        chk({tag, "_c_tvalid"}, 64'(m_axis_c_tvalid), 64'd0);
        chk({tag, "_c_tlast"}, 64'(m_axis_c_tlast), 64'd0);
        chk({tag, "_c_tdata"}, m_axis_c_tdata, 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        cfg_m = '0;
        cfg_n = '0;
        cfg_k = '0;
        s_axis_a_tdata = '0;
        s_axis_a_tvalid = 1'b0;
        s_axis_a_tlast = 1'b0;
        s_axis_b_tdata = '0;
        s_axis_b_tvalid = 1'b0;
        s_axis_b_tlast = 1'b0;
        m_axis_c_tready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic 2x2x2.
        set_basic();
        run_op(2, 2, 2, 2'b00);

        // Non-square with negative values: 1x2 times 2x3.
        a_vec = '{-32'sd3, 32'sd4};
        b_vec = '{32'sd1, 32'sd2, -32'sd5, 32'sd6, -32'sd7, 32'sd0};
        exp_q = '{64'sd21, -64'sd34, 64'sd15};
        a_last_idx = 1;
        run_op(1, 3, 2, 2'b00);

        // Backpressure on C.
        set_basic();
        bp_mode = 1'b1;
        run_op(2, 2, 2, 2'b00);

        // Early A tlast and missing B tlast.
        set_basic();
        a_last_idx = 1;
        b_omit_last = 1'b1;
        run_op(2, 2, 2, 2'b10);

        // Invalid configs.
        run_bad(2, 2, 0);
        run_bad(5, 2, 2);

        // Maximum tile: every C = 64 * (-1 * 2) = -128.
        set_basic();
        a_vec.delete();
        b_vec.delete();
        exp_q.delete();
        for (int i = 0; i < 256; i++) begin
            a_vec.push_back(32'hFFFF_FFFF);
            b_vec.push_back(32'd2);
        end
        for (int i = 0; i < 16; i++) exp_q.push_back(-64'sd128);
        a_last_idx = 255;
        run_op(4, 4, 64, 2'b00);

        // Reset during LOAD_B after an A tlast error.
        set_basic();
        a_last_idx = 1;
        cfg_m = 8'd2;
        cfg_n = 8'd2;
        cfg_k = 16'd2;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        drive_a();
        s_axis_b_tvalid = 1'b1;
        s_axis_b_tlast = 1'b0;
        s_axis_b_tdata = 32'd5;
        @(posedge clk); #1;
        s_axis_b_tdata = 32'd6;
        @(posedge clk); #1;
        chk("pre_rst_err", 64'(err), 64'd2);
        chk("pre_rst_b_tready", 64'(s_axis_b_tready), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_idle_outputs("mid_rst");
        rst = 1'b0;
        s_axis_b_tvalid = 1'b0;
        @(posedge clk); #1;

        // Rerun with a stray start during OUTPUT.
        set_basic();
        start_in_output = 1'b1;
        run_op(2, 2, 2, 2'b00);
        @(posedge clk); #1;
        chk("stray_start_busy", 64'(busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/matmul_tile_engine.md
Name: matmul_tile_engine

Overview:
- Parametrised AXI-Stream matrix-tile engine. Computes C = A·B, where A is M×K, B is K×N and C is M×N.
- M, N and K are set at run time and are bounded by compile-time maxima.
- Loads A, then B, over AXI-Stream slaves, runs one signed MAC per cycle, then streams C row-major over an AXI-Stream master.
- Sits between the DMA/stream front-end and the control/status register block, which drives cfg_* and start and samples busy, done and err.

Parameters:
- DATA_W, 32: element width of A and B (signed two's complement).
- ACC_W, 64: accumulator width and C output width; must be ≥ DATA_W.
- M_MAX, 4: maximum rows of A and C.
- N_MAX, 4: maximum columns of B and C.
- K_MAX, 64: maximum inner dimension.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- s_axis_a_tdata  in  DATA_W  A elements, row-major.
- s_axis_a_tvalid  in  1  A beat valid.
- s_axis_a_tready  out  1  A beat accepted.
- s_axis_a_tlast  in  1  marks the last A element.
- s_axis_b_tdata  in  DATA_W  B elements, row-major.
- s_axis_b_tvalid  in  1  B beat valid.
- s_axis_b_tready  out  1  B beat accepted.
- s_axis_b_tlast  in  1  marks the last B element.
- m_axis_c_tdata  out  ACC_W  C elements, row-major.
- m_axis_c_tvalid  out  1  C beat valid.
- m_axis_c_tready  in  1  downstream ready.
- m_axis_c_tlast  out  1  marks the last C element.
- cfg_m  in  8  rows M.
- cfg_n  in  8  columns N.
- cfg_k  in  16  inner dimension K.
- start  in  1  launch; sampled in IDLE only.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when C has fully drained.
- err  out  2  sticky flags: bit0 invalid config, bit1 tlast mismatch.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state IDLE; all tready, tvalid and tlast low; m_axis_c_tdata 0; done 0; busy 0; err 0; all counters 0.
- Reset mid-operation: at the next edge the block returns to IDLE with all outputs at reset values. Buffer contents are don't-care.
- FSM states: IDLE, LOAD_A, LOAD_B, COMPUTE, OUTPUT, DONE.
- IDLE:
  - When start=1, cfg_m, cfg_n and cfg_k are latched and err is cleared.
  - If any latched value is 0 or exceeds its maximum: err[0]=1, done pulses on the next cycle, and the FSM stays in IDLE.
  - Otherwise the FSM goes to LOAD_A.
- start outside IDLE is ignored.
- LOAD_A:
  - s_axis_a_tready=1.
  - Each handshake writes A[i][k] and advances k; k wraps to 0 and i increments.
  - After exactly M·K handshakes, next state is LOAD_B.
- LOAD_B: same as LOAD_A for B[k][j], with N·K beats; then next state is COMPUTE.
- tlast checking:
  - The beat count alone decides when a load ends; tlast never ends a load.
  - tlast=1 on a non-final beat, or tlast=0 on the final beat, sets err[1]. The load continues.
- COMPUTE:
  - Lasts exactly M·N·K cycles; ports are idle.
  - Loop order: k innermost, then j, then i.
  - Each cycle: acc[i][j] <= (k==0 ? 0 : acc[i][j]) + sext(A[i][k]·B[k][j]).
  - The product is a full 2·DATA_W signed value, sign-extended or truncated to ACC_W. The sum wraps modulo 2^ACC_W; there is no saturation.
  - Next state is OUTPUT.
- OUTPUT:
  - m_axis_c_tvalid=1 and m_axis_c_tdata=acc[i][j], in row-major order.
  - tdata and tlast are held stable while tready=0.
  - tlast=1 only on beat M·N−1.
  - After the final handshake, next state is DONE.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally. start does not need to drop.
- Latency from start to first C beat, with no input stalls: 1 + M·K + N·K + M·N·K cycles.
- Guarantees:
  - Exactly one state accepts data on each slave.
  - No C beat is ever produced outside OUTPUT.
  - A and B streams are never accepted simultaneously.

Decomposition:
- Package matmul_pkg holds:
  - state_t enum;
  - localparams ERR_CFG=0 and ERR_TLAST=1;
  - function cnt_w(max), returning $clog2(max)+1, used for counter widths.
- One sub-module, mac_unit: a combinational signed DATA_W×DATA_W multiply with ACC_W wrap-add. It takes a clear input that selects 0 in place of the accumulator when k==0.
- Buffers, counters and the FSM stay in matmul_tile_engine.

Test Plan:
- Basic 2×2×2: A={1,2,3,4}, B={5,6,7,8}, tready=1. C must be {19,22,43,50} with tlast on beat 3, done a single pulse, err=0. First C beat appears 17 cycles after start.
- Maximum tile M=N=4, K=64, all A=−1, B=2. Result: 16 C beats, each −128. COMPUTE lasts exactly 1024 cycles.
- Backpressure on C: toggle tready 1-0-1 on every beat in the 2×2×2 case. Result: values unchanged, tdata stable while stalled, exactly 4 handshakes.
- tlast errors: assert A tlast on beat 1 of 4, and omit B tlast. Result: err=2'b10, loads still take 4 beats each, C is correct.
- Invalid config: cfg_k=0, or cfg_m=5 with M_MAX=4. Result: err=2'b01, done pulses, tready never rises, busy stays 0.
- Reset during LOAD_B, then start 2×2×2 again: the next cycle shows IDLE with all outputs 0. The rerun produces correct C, and a start pulse during OUTPUT is ignored.
